trivium_ctrl: RTL and testbench
===============================

TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

Interface
REQ-001 SHALL have parameter WARMUP_STEPS, default 1152, giving the number of discarded init rounds (4 x 288).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the output byte FIFO depth (power of two, >=2).
REQ-003 SHALL have parameter BYTE_LIMIT, default 65536, giving the bytes delivered per key/IV before rekey (used only with the macro).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to (re)initialise with key/iv.
REQ-007 SHALL have ports key and iv, input, 80 each: captured on an accepted start.
REQ-008 SHALL have port busy, output, 1: high in LOAD or WARMUP.
REQ-009 SHALL have port core_load, output, 1: one-cycle load strobe to the Trivium core.
REQ-010 SHALL have ports core_key and core_iv, output, 80 each: captured key/iv, stable from LOAD until the next accepted start.
REQ-011 SHALL have port core_step, output, 1: advance the core one round.
REQ-012 SHALL have port core_z, input, 1: core keystream bit, combinationally valid for the current state.
REQ-013 SHALL have port keystream_byte, output, 8: FIFO head.
REQ-014 SHALL have port keystream_valid, output, 1: FIFO non-empty.
REQ-015 SHALL have port keystream_read, input, 1: pop strobe.
REQ-016 SHALL have port rekey_req, output, 1: byte budget exhausted.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WARMUP, RUN, LIMIT.
REQ-018 SHALL accept start in IDLE, RUN or LIMIT: capture key/iv, flush FIFO and bit packer, clear byte counter, go to LOAD; SHALL ignore start in LOAD/WARMUP.
REQ-019 SHALL assert core_load for exactly the one LOAD cycle, then enter WARMUP.
REQ-020 SHALL assert core_step for exactly WARMUP_STEPS consecutive WARMUP cycles, discard core_z, then enter RUN.
REQ-021 SHALL, in RUN, assert core_step iff FIFO occupancy < FIFO_DEPTH, sampling core_z in the same cycle.
REQ-022 SHALL pack bits LSB-first: first sampled bit is keystream_byte[0]; the 8th bit pushes the byte at that clock edge.
REQ-023 SHALL, given start in cycle 0 and no backpressure, assert core_load in cycle 1 and core_step in cycles 2..1161, and raise keystream_valid in cycle 1162.
REQ-024 SHALL pop on keystream_read && keystream_valid; keystream_read while empty SHALL have no effect.
REQ-025 SHALL allow simultaneous push and pop when full; occupancy is then unchanged and core_step stays asserted that cycle.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH with no lost or duplicated bytes.

Reset
REQ-027 SHALL, on rst, set the state to IDLE, clear the FIFO, packer and counters, and drive busy, core_load, core_step, keystream_valid and rekey_req to 0, keystream_byte to 8'h00, and core_key/core_iv to 0.
REQ-028 SHALL give rst priority over start; a reset mid-WARMUP or mid-RUN SHALL abort without any further core_step.

Configuration
REQ-029 SHALL, when TRIVIUM_CTRL_BYTE_LIMIT_EN is defined, count pushed bytes and move RUN->LIMIT on the BYTE_LIMIT-th push, stop core_step, hold rekey_req high until an accepted start, and keep draining the FIFO.
REQ-030 SHALL, when TRIVIUM_CTRL_BYTE_LIMIT_EN is undefined, never enter LIMIT, omit the counter and tie rekey_req to 0; the port is always present.

Structure
REQ-031 SHALL place the state enum, KEY_W=80, IV_W=80 and STATE_BITS=288 in the shared package trivium_pkg.
REQ-032 SHALL implement the byte FIFO as the sub-module trivium_ks_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-033 Start with no backpressure (model core, z pattern 1,0,1,1,0,0,0,0 after warmup) -> core_load in cycle 1, first valid in cycle 1162, keystream_byte=8'h0D.
REQ-034 keystream_read held low -> exactly 4 bytes buffered, core_step low from the 32nd RUN step; one pop -> exactly 8 more steps.
REQ-035 Start pulsed in cycle 500 of WARMUP -> ignored, warmup finishes at cycle 1153; start in RUN with 3 bytes queued -> keystream_valid low next cycle, new LOAD.
REQ-036 rst asserted mid-RUN with full FIFO -> next cycle IDLE, valid 0, core_step 0; keystream_read while empty -> no change.
REQ-037 With TRIVIUM_CTRL_BYTE_LIMIT_EN and BYTE_LIMIT=16 -> rekey_req rises after the 16th push, 16 bytes total delivered, cleared on start.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium keystream controller.
package trivium_pkg;

   localparam int KEY_W      = 80;
   localparam int IV_W       = 80;
   localparam int STATE_BITS = 288;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WARMUP = 3'd2,
      ST_RUN    = 3'd3,
      ST_LIMIT  = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/trivium_ks_fifo.sv
// Keystream byte FIFO: power-of-two depth, synchronous flush, push/pop in the same
// cycle allowed when full. Head reads as 8'h00 while empty.
module trivium_ks_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [7:0]               data_i,
   input  logic                     pop_i,
   output logic [7:0]               data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push_s, do_pop_s;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == DEPTH_C);
   assign count_o   = cnt_q;
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         // Pointers wrap on their own because DEPTH is a power of two.
         if (do_push_s) wr_ptr_d = wr_ptr_q + 1'b1;
         else           wr_ptr_d = wr_ptr_q;
         if (do_pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
         else           rd_ptr_d = rd_ptr_q;
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   always_comb begin
      if (empty_o) data_o = 8'h00;
      else         data_o = mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/trivium_ctrl.sv
// Trivium core sequencer: load, warm-up, LSB-first byte packing into a FIFO.
// Optional byte budget with rekey request under TRIVIUM_CTRL_BYTE_LIMIT_EN.
module trivium_ctrl
   import trivium_pkg::*;
#(
   parameter int WARMUP_STEPS = 4 * STATE_BITS,
   parameter int FIFO_DEPTH   = 4,
   parameter int BYTE_LIMIT   = 65536
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KEY_W-1:0] key,
   input  logic [IV_W-1:0]  iv,
   output logic             busy,
   output logic             core_load,
   output logic [KEY_W-1:0] core_key,
   output logic [IV_W-1:0]  core_iv,
   output logic             core_step,
   input  logic             core_z,
   output logic [7:0]       keystream_byte,
   output logic             keystream_valid,
   input  logic             keystream_read,
   output logic             rekey_req
);

   localparam int WCW = $clog2(WARMUP_STEPS + 1);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_STEPS - 1);
   localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

   ctrl_state_e      state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [IV_W-1:0]  iv_q, iv_d;
   logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
   logic [7:0]       pack_q, pack_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;

   logic          accept_s, pop_s, push_s, step_ok_s, run_step_s, limit_hit_s;
   logic          fifo_full_s, fifo_empty_s;
   logic [CW-1:0] fifo_count_s;

   assign accept_s   = start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_LIMIT);
   assign pop_s      = keystream_read && !fifo_empty_s;
   // A pop while full frees the slot the 8th bit would land in, so stepping may continue.
   assign step_ok_s  = (fifo_count_s < DEPTH_C) || (fifo_full_s && pop_s);
   assign run_step_s = (state_q == ST_RUN) && step_ok_s;
   assign push_s     = run_step_s && (bit_cnt_q == 3'd7);

`ifdef TRIVIUM_CTRL_BYTE_LIMIT_EN
   localparam int BCW = $clog2(BYTE_LIMIT + 1);
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;

   assign limit_hit_s = push_s && (byte_cnt_q == BCW'(BYTE_LIMIT - 1));
   assign rekey_req   = (state_q == ST_LIMIT);

   always_comb begin
      if (accept_s)    byte_cnt_d = '0;
      else if (push_s) byte_cnt_d = byte_cnt_q + 1'b1;
      else             byte_cnt_d = byte_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) byte_cnt_q <= '0;
      else     byte_cnt_q <= byte_cnt_d;
   end
`else
   logic unused_limit_s;
   assign unused_limit_s = (BYTE_LIMIT > 0);
   assign limit_hit_s    = 1'b0;
   assign rekey_req      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         key_q      <= '0;
         iv_q       <= '0;
         warm_cnt_q <= '0;
         pack_q     <= 8'h00;
         bit_cnt_q  <= 3'd0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         iv_q       <= iv_d;
         warm_cnt_q <= warm_cnt_d;
         pack_q     <= pack_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = accept_s ? ST_LOAD : ST_IDLE;
         ST_LOAD:   state_d = ST_WARMUP;
         ST_WARMUP: state_d = (warm_cnt_q == WARM_LAST) ? ST_RUN : ST_WARMUP;
         ST_RUN: begin
            if (accept_s)         state_d = ST_LOAD;
            else if (limit_hit_s) state_d = ST_LIMIT;
            else                  state_d = ST_RUN;
         end
         ST_LIMIT:  state_d = accept_s ? ST_LOAD : ST_LIMIT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         ST_LOAD:   begin busy = 1'b1; core_load = 1'b1; end
         ST_WARMUP: begin busy = 1'b1; core_step = 1'b1; end
         ST_RUN:    core_step = step_ok_s;
         default:   core_step = 1'b0;
      endcase
   end

   always_comb begin
      key_d      = key_q;
      iv_d       = iv_q;
      pack_d     = pack_q;
      bit_cnt_d  = bit_cnt_q;
      warm_cnt_d = (state_q == ST_WARMUP) ? warm_cnt_q + 1'b1 : '0;
      if (accept_s) begin
         key_d     = key;
         iv_d      = iv;
         pack_d    = 8'h00;
         bit_cnt_d = 3'd0;
      end else if (run_step_s) begin
         // Shift right so the first sampled bit ends up in bit 0.
         pack_d    = {core_z, pack_q[7:1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
         pack_d    = pack_q;
         bit_cnt_d = bit_cnt_q;
      end
   end

   assign core_key        = key_q;
   assign core_iv         = iv_q;
   assign keystream_valid = !fifo_empty_s;

   trivium_ks_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (accept_s),
      .push_i  (push_s),
      .data_i  ({core_z, pack_q[7:1]}),
      .pop_i   (keystream_read),
      .data_o  (keystream_byte),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

endmodule

// File: tb/tb_trivium_ctrl.sv
// Self-checking bench for trivium_ctrl: cycle-table for the start sequence,
// hand sequences for backpressure/restart/reset, randomized reads vs a bit-stream model.
`timescale 1ns/1ps
module tb_trivium_ctrl;

   localparam int WARM  = 1152;
   localparam int DEPTH = 4;
`ifdef TRIVIUM_CTRL_BYTE_LIMIT_EN
   localparam int LIMIT  = 16;
   localparam bit LIM_EN = 1'b1;
`else
   localparam int LIMIT  = 65536;
   localparam bit LIM_EN = 1'b0;
`endif
   localparam int ZN = 16384;

   logic        clk = 1'b0;
   logic        rst, start, core_z, keystream_read;
   logic [79:0] key, iv, core_key, core_iv;
   logic        busy, core_load, core_step, keystream_valid, rekey_req;
   logic [7:0]  keystream_byte;

   always #5 clk = ~clk;

   trivium_ctrl #(.WARMUP_STEPS(WARM), .FIFO_DEPTH(DEPTH), .BYTE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
      .busy(busy), .core_load(core_load), .core_key(core_key), .core_iv(core_iv),
      .core_step(core_step), .core_z(core_z),
      .keystream_byte(keystream_byte), .keystream_valid(keystream_valid),
      .keystream_read(keystream_read), .rekey_req(rekey_req)
   );

   // Stand-in core: counts rounds since load; after warm-up emits the zbits stream.
   bit zbits [ZN];
   int idx = 0;
   always @(posedge clk) begin
      if (core_load)      idx <= 0;
      else if (core_step) idx <= idx + 1;
   end
   always_comb core_z = (idx >= WARM) ? zbits[(idx - WARM) % ZN] : idx[0];

   function automatic logic [7:0] ref_byte(input int k);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = zbits[(8 * k + b) % ZN];
      return r;
   endfunction

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct {
      int         cyc;
      bit         start;
      bit         e_busy, e_load, e_step, e_valid;
      logic [7:0] e_byte;
   } row_t;

   row_t        rows[$];
   logic [79:0] key_a, iv_a, key_b, iv_b;
   logic [7:0]  pat;
   int          steps, popped, n, base;

   initial begin
      pat = 8'b0000_1101;
      for (int i = 0; i < ZN; i++) zbits[i] = (i < 8) ? pat[i[2:0]] : 1'($urandom);
      key_a = {16'($urandom), $urandom, $urandom};
      iv_a  = {16'($urandom), $urandom, $urandom};
      key_b = {16'($urandom), $urandom, $urandom};
      iv_b  = {16'($urandom), $urandom, $urandom};

      rows.push_back('{0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
      rows.push_back('{1,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
      rows.push_back('{2,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
      rows.push_back('{500,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
      rows.push_back('{501,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
      rows.push_back('{1153, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
      rows.push_back('{1154, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      rows.push_back('{1161, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      rows.push_back('{1162, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0D});
      rows.push_back('{1185, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0D});
      rows.push_back('{1186, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D});
      rows.push_back('{1190, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D});

      rst = 1'b1; start = 1'b0; keystream_read = 1'b0; key = key_a; iv = iv_a;
      repeat (3) next_cycle();
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_load", core_load, 1'b0);
      check("rst_step", core_step, 1'b0);
      check("rst_valid", keystream_valid, 1'b0);
      check("rst_byte", keystream_byte, 8'h00);
      check("rst_rekey", rekey_req, 1'b0);
      check("rst_key", core_key, 80'h0);
      check("rst_iv", core_iv, 80'h0);

      next_cycle();
      rst = 1'b0;
      cyc = 0;
      for (int r = 0; r < rows.size(); r++) begin
         while (cyc < rows[r].cyc) begin start = 1'b0; next_cycle(); end
         start = rows[r].start;
         key   = (cyc == 0) ? key_a : key_b;
         iv    = (cyc == 0) ? iv_a : iv_b;
         @(negedge clk);
         check($sformatf("busy@%0d", cyc), busy, rows[r].e_busy);
         check($sformatf("load@%0d", cyc), core_load, rows[r].e_load);
         check($sformatf("step@%0d", cyc), core_step, rows[r].e_step);
         check($sformatf("valid@%0d", cyc), keystream_valid, rows[r].e_valid);
         if (rows[r].e_valid) check($sformatf("byte@%0d", cyc), keystream_byte, rows[r].e_byte);
         next_cycle();
         start = 1'b0;
      end
      check("key_kept", core_key, key_a);
      check("iv_kept", core_iv, iv_a);
      check("steps_to_full", idx, WARM + 32);
      check("rekey_run", rekey_req, 1'b0);

      // One pop while full: stepping resumes that cycle and refills after 8 rounds.
      steps = 0;
      keystream_read = 1'b1;
      @(negedge clk);
      check("pop0_byte", keystream_byte, ref_byte(0));
      check("pop_full_step", core_step, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         steps += int'(core_step);
         next_cycle();
         keystream_read = 1'b0;
      end
      check("refill_steps", steps, 8);
      check("refill_full_valid", keystream_valid, 1'b1);

      // Pop again then restart with 3 bytes queued.
      keystream_read = 1'b1;
      @(negedge clk);
      check("pop1_byte", keystream_byte, ref_byte(1));
      next_cycle();
      keystream_read = 1'b0;
      start = 1'b1; key = key_b; iv = iv_b;
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check("restart_valid", keystream_valid, 1'b0);
      check("restart_load", core_load, 1'b1);
      check("restart_key", core_key, key_b);

      n = 0;
      while (!keystream_valid && n < 1400) begin next_cycle(); @(negedge clk); n++; end
      check("warmup2_done", keystream_valid, 1'b1);

      // Randomized reads; every popped byte is matched against the bit stream.
      popped = 0;
      for (int i = 0; i < 1500; i++) begin
         next_cycle();
         keystream_read = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (keystream_read && keystream_valid) begin
            check($sformatf("rand_byte%0d", popped), keystream_byte, ref_byte(popped));
            popped++;
         end
      end
      n = 0;
      next_cycle();
      keystream_read = 1'b1;
      @(negedge clk);
      while (keystream_valid && n < 200) begin
         check($sformatf("drain_byte%0d", popped), keystream_byte, ref_byte(popped));
         popped++;
         next_cycle();
         @(negedge clk);
         n++;
      end
      check("drain_empty", keystream_valid, 1'b0);
      check("no_lost_bytes", popped, (idx - WARM) / 8);
      if (LIM_EN) begin
         check("limit_total", popped, LIMIT);
         check("limit_rekey", rekey_req, 1'b1);
         check("limit_nostep", core_step, 1'b0);
      end else begin
         check("nolimit_rekey", rekey_req, 1'b0);
      end
      next_cycle();
      keystream_read = 1'b0;

      start = 1'b1; key = key_a; iv = iv_a;
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check("start_clears_rekey", rekey_req, 1'b0);
      check("start3_load", core_load, 1'b1);
      repeat (WARM + 40) next_cycle();
      @(negedge clk);
      check("full_again", keystream_valid, 1'b1);
      check("full_nostep", core_step, 1'b0);

      // Reset together with start mid-RUN: reset wins.
      base = idx;
      rst = 1'b1; start = 1'b1;
      next_cycle();
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_run_busy", busy, 1'b0);
      check("rst_run_load", core_load, 1'b0);
      check("rst_run_step", core_step, 1'b0);
      check("rst_run_valid", keystream_valid, 1'b0);
      check("rst_run_key", core_key, 80'h0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         keystream_read = 1'b1;
         @(negedge clk);
         check($sformatf("empty_read_valid%0d", i), keystream_valid, 1'b0);
         check($sformatf("empty_read_byte%0d", i), keystream_byte, 8'h00);
         check($sformatf("empty_read_step%0d", i), core_step, 1'b0);
      end
      check("rst_no_more_steps", idx, base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
